// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one clock; the two halves run independently.
// Both state machines are exposed on tx_state_dbg / rx_state_dbg for checker binding.
module uart_transceiver #(
    parameter int CLOCKS_PER_BIT = 325
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_bit,
    input  logic [7:0] tx_data_byte,
    output logic       tx_serial,
    output logic       tx_active,
    output logic       tx_done,
    input  logic       rx_serial,
    output logic [7:0] w_rx_byte,
    output logic       rx_done,
    output logic [2:0] tx_state_dbg,
    output logic [2:0] rx_state_dbg
);

    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLOCKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } state_t;

    state_t        tx_state;
    logic [CW-1:0] tx_count;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    state_t        rx_state;
    logic [CW-1:0] rx_count;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_meta;
    logic          rx_sync;

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

    // tx_shift[0] always holds the next data bit to put on the line.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state  <= S_IDLE;
            tx_count  <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    tx_count  <= '0;
                    tx_idx    <= '0;
                    if (tx_bit) begin
                        tx_shift  <= tx_data_byte;
                        tx_serial <= 1'b0;
                        tx_active <= 1'b1;
                        tx_state  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_count == LAST) begin
                        tx_count  <= '0;
                        tx_serial <= tx_shift[0];
                        tx_shift  <= {1'b0, tx_shift[7:1]};
                        tx_state  <= S_DATA;
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_count == LAST) begin
                        tx_count <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            tx_state  <= S_STOP;
                        end else begin
                            tx_idx    <= tx_idx + 1'b1;
                            tx_serial <= tx_shift[0];
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_count == LAST) begin
                        tx_count  <= '0;
                        tx_done   <= 1'b1;
                        tx_active <= 1'b0;
                        tx_serial <= 1'b1;
                        tx_state  <= S_CLEANUP;
                    end else begin
                        tx_count <= tx_count + 1'b1;
                    end
                end
                S_CLEANUP: tx_state <= S_IDLE;
                default:   tx_state <= S_IDLE;
            endcase
        end
    end

    // Samples are taken mid-bit: HALF cycles into the start bit, then every CLOCKS_PER_BIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_state  <= S_IDLE;
            rx_count  <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            w_rx_byte <= 8'h00;
            rx_done   <= 1'b0;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
            rx_done <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    rx_count <= '0;
                    rx_idx   <= '0;
                    if (!rx_sync) rx_state <= S_START;
                end
                S_START: begin
                    if (rx_count == HALF) begin
                        rx_count <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_count <= rx_count + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_count == LAST) begin
                        rx_count <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state <= S_STOP;
                        else                rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_count <= rx_count + 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_count == LAST) begin
                        rx_count <= '0;
                        if (rx_sync) begin
                            w_rx_byte <= rx_shift;
                            rx_done   <= 1'b1;
                        end
                        rx_state <= S_CLEANUP;
                    end else begin
                        rx_count <= rx_count + 1'b1;
                    end
                end
                S_CLEANUP: rx_state <= S_IDLE;
                default:   rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: frame-level model of 8N1 timing and a
// received-byte scoreboard fed either by loopback or by directly driven rx frames.
module tb_uart_transceiver;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_bit;
    logic [7:0] tx_data_byte;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;
    logic       rx_serial;
    logic [7:0] w_rx_byte;
    logic       rx_done;
    logic [2:0] tx_state_dbg;
    logic [2:0] rx_state_dbg;

    logic       loop_en;
    logic       rx_drive;

    int checks      = 0;
    int errors      = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_rx;
    logic [7:0] mon_exp;

    assign rx_serial = loop_en ? tx_serial : rx_drive;

    uart_transceiver #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_bit       (tx_bit),
        .tx_data_byte (tx_data_byte),
        .tx_serial    (tx_serial),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .rx_serial    (rx_serial),
        .w_rx_byte    (w_rx_byte),
        .rx_done      (rx_done),
        .tx_state_dbg (tx_state_dbg),
        .rx_state_dbg (rx_state_dbg)
    );

    // clock
    always #5 clock = ~clock;

    // scoreboard: every rx_done must match the oldest expected byte
    always @(negedge clock) begin
        if (tx_done === 1'b1) tx_done_cnt++;
        if (rx_done === 1'b1) begin
            rx_done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got byte %02h, required no rx_done", w_rx_byte);
            end else begin
                mon_exp  = exp_q.pop_front();
                model_rx = mon_exp;
                if (w_rx_byte !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_byte: got %02h, required %02h", w_rx_byte, mon_exp);
                end
            end
        end
    end

    // Walks one transmit frame negedge by negedge; negedge n follows edge E0+n.
    task automatic check_frame(input logic [7:0] b, input int from_n, input int pulse_n,
                               input bit chk_rx, input int rx_cnt0);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int n = from_n; n <= FRAME; n++) begin
            @(negedge clock);
            if (pulse_n >= 0 && n == pulse_n) begin
                tx_bit       = 1'b1;
                tx_data_byte = 8'h12;
            end else if (pulse_n >= 0 && n == pulse_n + 1) begin
                tx_bit = 1'b0;
            end
            if (n < FRAME) begin
                if ((n % CPB) == CPB / 2) begin
                    checks++;
                    if (tx_serial !== frame[n/CPB]) begin
                        errors++;
                        $display("FAIL tx_bit%0d byte %02h: got %b, required %b", n / CPB, b,
                                 tx_serial, frame[n/CPB]);
                    end
                    checks++;
                    if (tx_active !== 1'b1 || tx_done !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_busy n=%0d: got active=%b done=%b, required 1 0", n,
                                 tx_active, tx_done);
                    end
                end
                if (n == FRAME - 1) begin
                    checks++;
                    if (tx_done !== 1'b0) begin
                        errors++;
                        $display("FAIL tx_done_early: got %b, required 0", tx_done);
                    end
                end
            end else begin
                checks++;
                if (tx_done !== 1'b1 || tx_active !== 1'b0 || tx_serial !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_end byte %02h: got done=%b active=%b line=%b, required 1 0 1",
                             b, tx_done, tx_active, tx_serial);
                end
                if (chk_rx) begin
                    checks++;
                    if (w_rx_byte !== b || rx_done_cnt <= rx_cnt0) begin
                        errors++;
                        $display("FAIL loopback_by_done: got %02h (rx_done %0d), required %02h",
                                 w_rx_byte, rx_done_cnt - rx_cnt0, b);
                    end
                end
            end
        end
        @(negedge clock);
        checks++;
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL tx_done_width: got %b, required 0", tx_done);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int pulse_n);
        int c0;
        @(negedge clock);
        tx_bit       = 1'b1;
        tx_data_byte = b;
        exp_q.push_back(b);
        c0 = rx_done_cnt;
        @(posedge clock);
        #1;
        tx_bit       = 1'b0;
        tx_data_byte = 8'($urandom);
        check_frame(b, 0, pulse_n, 1'b1, c0);
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drive = f[k];
            repeat (CPB) @(negedge clock);
        end
        rx_drive = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        tx_bit       = 1'b0;
        tx_data_byte = 8'h00;
        loop_en      = 1'b1;
        rx_drive     = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 ||
            w_rx_byte !== 8'h00 || rx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got line=%b active=%b done=%b rx=%02h rxd=%b, required 1 0 0 00 0",
                     tx_serial, tx_active, tx_done, w_rx_byte, rx_done);
        end
        reset    = 1'b0;
        model_rx = 8'h00;
        repeat (4) @(negedge clock);
        checks++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL idle_line: got line=%b active=%b, required 1 0", tx_serial, tx_active);
        end
    endtask

    task automatic test_loopback();
        loop_en = 1'b1;
        send_frame(8'hAB, -1);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 5)) @(negedge clock);
            send_frame(8'($urandom), -1);
        end
    endtask

    task automatic test_back_to_back();
        int  c0;
        int  t0;
        int  c1;
        bit  found;
        loop_en = 1'b1;
        repeat (3) @(negedge clock);
        t0 = tx_done_cnt;
        c0 = rx_done_cnt;
        tx_bit       = 1'b1;
        tx_data_byte = 8'h00;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        @(posedge clock);
        #1;
        tx_data_byte = 8'hFF;
        check_frame(8'h00, 0, -1, 1'b1, c0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clock);
            if (tx_active === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL b2b_restart: got no second frame within 4 cycles, required restart");
            tx_bit = 1'b0;
        end else begin
            tx_bit = 1'b0;
            c1 = rx_done_cnt;
            check_frame(8'hFF, 1, -1, 1'b1, c1);
        end
        checks++;
        if (tx_done_cnt - t0 != 2 || rx_done_cnt - c0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got tx_done %0d rx_done %0d, required 2 2",
                     tx_done_cnt - t0, rx_done_cnt - c0);
        end
    endtask

    task automatic test_busy_request();
        bit saw;
        loop_en = 1'b1;
        repeat (3) @(negedge clock);
        send_frame(8'h34, 3 * CPB);
        saw = 1'b0;
        repeat (12 * CPB) begin
            @(negedge clock);
            if (tx_active !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL busy_request: got an extra frame, required only 34");
        end
    endtask

    task automatic test_glitch();
        int c0;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat (4) @(negedge clock);
        c0 = rx_done_cnt;
        rx_drive = 1'b0;
        repeat (CPB / 4) @(negedge clock);
        rx_drive = 1'b1;
        repeat (12 * CPB) @(negedge clock);
        checks++;
        if (rx_done_cnt != c0 || w_rx_byte !== model_rx) begin
            errors++;
            $display("FAIL glitch: got rx_done %0d byte %02h, required 0 %02h",
                     rx_done_cnt - c0, w_rx_byte, model_rx);
        end
    endtask

    task automatic test_framing_error();
        int         c0;
        logic [7:0] r;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat (4) @(negedge clock);
        c0 = rx_done_cnt;
        drive_rx_frame(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clock);
        checks++;
        if (rx_done_cnt != c0 || w_rx_byte !== model_rx) begin
            errors++;
            $display("FAIL framing_error: got rx_done %0d byte %02h, required 0 %02h",
                     rx_done_cnt - c0, w_rx_byte, model_rx);
        end
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            drive_rx_frame(r, 1'b1);
            repeat ($urandom_range(2, 6)) @(negedge clock);
        end
        repeat (CPB) @(negedge clock);
        checks++;
        if (rx_done_cnt != c0 + 3) begin
            errors++;
            $display("FAIL rx_recover: got rx_done %0d, required 3", rx_done_cnt - c0);
        end
    endtask

    task automatic test_full_duplex();
        int         c0;
        logic [7:0] r;
        logic [7:0] t;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat (4) @(negedge clock);
        r  = 8'($urandom);
        t  = 8'($urandom);
        c0 = rx_done_cnt;
        exp_q.push_back(r);
        fork
            begin
                @(negedge clock);
                tx_bit       = 1'b1;
                tx_data_byte = t;
                @(posedge clock);
                #1;
                tx_bit = 1'b0;
                check_frame(t, 0, -1, 1'b0, 0);
            end
            begin
                drive_rx_frame(r, 1'b1);
            end
        join
        repeat (CPB) @(negedge clock);
        checks++;
        if (rx_done_cnt != c0 + 1) begin
            errors++;
            $display("FAIL full_duplex_rx: got rx_done %0d, required 1", rx_done_cnt - c0);
        end
    endtask

    task automatic test_reset_abort();
        int t0;
        loop_en  = 1'b0;
        rx_drive = 1'b1;
        repeat (4) @(negedge clock);
        t0 = tx_done_cnt;
        tx_bit       = 1'b1;
        tx_data_byte = 8'($urandom_range(1, 255));
        @(posedge clock);
        #1;
        tx_bit = 1'b0;
        for (int n = 0; n < 3 * CPB; n++) begin
            @(negedge clock);
            if (n == 3 * CPB - 1) reset = 1'b1;
        end
        @(negedge clock);
        checks++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || tx_done !== 1'b0 || w_rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: got line=%b active=%b done=%b rx=%02h, required 1 0 0 00",
                     tx_serial, tx_active, tx_done, w_rx_byte);
        end
        reset    = 1'b0;
        model_rx = 8'h00;
        repeat (9 * CPB) @(negedge clock);
        checks++;
        if (tx_done_cnt != t0 || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got tx_done %0d active=%b, required 0 0",
                     tx_done_cnt - t0, tx_active);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_busy_request();
        test_glitch();
        test_framing_error();
        test_full_duplex();
        test_reset_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rx_missing: got %0d bytes never received, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
